// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
interface serial_adder_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             START;
    logic             MODE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] SUM;
    logic             Carry;
    logic             OVF;
    logic             BUSY;
    logic             DONE;

    // Requester side: issues operations and observes results.
    modport master (
        output START, MODE, A, B,
        input  SUM, Carry, OVF, BUSY, DONE
    );

    // Adder side: accepts operations and returns results.
    modport slave (
        input  START, MODE, A, B,
        output SUM, Carry, OVF, BUSY, DONE
    );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice, registered carry, WIDTH+1 cycle throughput.
module serial_adder_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           CLK,
    input  logic           nRST,
    serial_adder_n_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s_bit;
    logic               c_nx;
    logic [WIDTH-1:0]   res_shift;

    // Single full-adder slice on the operand LSBs and the running carry.
    always_comb begin
        s_bit     = opa_q[0] ^ opb_q[0] ^ c_q;
        c_nx      = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
        res_shift = {s_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath control; FINISH accepts START just like IDLE.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (bus.START) begin
                    opa_d   = bus.A;
                    opb_d   = bus.MODE ? ~bus.B : bus.B;
                    res_d   = '0;
                    c_d     = bus.MODE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                opa_d  = opa_q >> 1;
                opb_d  = opb_q >> 1;
                res_d  = res_shift;
                c_d    = c_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // c_q is the carry into the MSB on this final step.
                    sum_d   = res_shift;
                    carry_d = c_nx;
                    ovf_d   = c_q ^ c_nx;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SUM   = sum_q;
    assign bus.Carry = carry_q;
    assign bus.OVF   = ovf_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: 8-bit and 2-bit instances on a shared clock/reset.
module tb_serial_adder_n;
    typedef struct {
        logic [31:0] sum;
        logic [31:0] carry;
        logic [31:0] ovf;
        int          cyc;
    } exp_t;

    logic CLK;
    logic nRST;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   busy8;
    int   done8;
    int   done2;
    exp_t q8[$];
    exp_t q2[$];

    serial_adder_n_if #(.WIDTH(8)) bus8 ();
    serial_adder_n_if #(.WIDTH(2)) bus2 ();

    serial_adder_n #(.WIDTH(8)) u8 (.CLK(CLK), .nRST(nRST), .bus(bus8));
    serial_adder_n #(.WIDTH(2)) u2 (.CLK(CLK), .nRST(nRST), .bus(bus2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic: A + B, or A + ~B + 1, with overflow from carry into/out of the MSB.
    function automatic exp_t model(input int w, input logic mode, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint mask;
        longint m1;
        longint aa;
        longint bb;
        longint t;
        longint tl;
        mask  = (64'sd1 <<< w) - 1;
        m1    = mask >>> 1;
        aa    = longint'(a) & mask;
        bb    = (mode ? ~longint'(b) : longint'(b)) & mask;
        t     = aa + bb + (mode ? 64'sd1 : 64'sd0);
        tl    = (aa & m1) + (bb & m1) + (mode ? 64'sd1 : 64'sd0);
        e.sum   = 32'(t & mask);
        e.carry = 32'((t >>> w) & 1);
        e.ovf   = 32'(((tl >>> (w - 1)) & 1) ^ ((t >>> w) & 1));
        e.cyc   = 0;
        return e;
    endfunction

    // Result monitor, 8-bit instance: every DONE must match the oldest pending expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus8.BUSY) busy8++;
        if (bus8.DONE) begin
            done8++;
            chk("done8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("sum8", 32'(bus8.SUM), e.sum);
                chk("carry8", 32'(bus8.Carry), e.carry);
                chk("ovf8", 32'(bus8.OVF), e.ovf);
                chk("done8_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Result monitor, 2-bit instance.
    always @(negedge CLK) begin
        exp_t e;
        if (bus2.DONE) begin
            done2++;
            chk("done2_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("sum2", 32'(bus2.SUM), e.sum);
                chk("carry2", 32'(bus2.Carry), e.carry);
                chk("ovf2", 32'(bus2.OVF), e.ovf);
                chk("done2_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start8(input logic mode, input logic [7:0] a, input logic [7:0] b,
                          input bit push);
        exp_t e;
        @(posedge CLK); #2;
        bus8.START = 1'b1;
        bus8.MODE  = mode;
        bus8.A     = a;
        bus8.B     = b;
        if (push) begin
            e     = model(8, mode, 32'(a), 32'(b));
            e.cyc = cyc + 1 + 8;
            q8.push_back(e);
        end
        @(posedge CLK); #2;
        bus8.START = 1'b0;
        bus8.A     = $urandom_range(255, 0);
        bus8.B     = $urandom_range(255, 0);
        bus8.MODE  = ~mode;
    endtask

    task automatic start2(input logic mode, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        @(posedge CLK); #2;
        bus2.START = 1'b1;
        bus2.MODE  = mode;
        bus2.A     = a;
        bus2.B     = b;
        e     = model(2, mode, 32'(a), 32'(b));
        e.cyc = cyc + 1 + 2;
        q2.push_back(e);
        @(posedge CLK); #2;
        bus2.START = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < budget) begin
            @(posedge CLK); #2;
            n++;
        end
        chk(tag, 32'(q8.size() + q2.size()), 32'd0);
        @(posedge CLK); #2;
    endtask

    initial begin
        int b0;
        int d0;
        int c0;
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        busy8   = 0;
        done8   = 0;
        done2   = 0;
        nRST    = 1'b0;
        bus8.START = 1'b0; bus8.MODE = 1'b0; bus8.A = '0; bus8.B = '0;
        bus2.START = 1'b0; bus2.MODE = 1'b0; bus2.A = '0; bus2.B = '0;

        // Reset values.
        #1;
        chk("rst_sum", 32'(bus8.SUM), 32'd0);
        chk("rst_carry", 32'(bus8.Carry), 32'd0);
        chk("rst_ovf", 32'(bus8.OVF), 32'd0);
        chk("rst_busy", 32'(bus8.BUSY), 32'd0);
        chk("rst_done", 32'(bus8.DONE), 32'd0);
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        // 0x5A + 0x3C: eight BUSY cycles, DONE eight cycles after capture.
        b0 = busy8;
        start8(1'b0, 8'h5A, 8'h3C, 1'b1);
        drain("drain_5a3c", 40);
        chk("busy_cycles_5a3c", 32'(busy8 - b0), 32'd8);
        chk("sum_const_5a3c", 32'(bus8.SUM), 32'h96);
        chk("ovf_const_5a3c", 32'(bus8.OVF), 32'd1);

        // Carry out of the MSB, then subtract with borrow.
        start8(1'b0, 8'hFF, 8'h01, 1'b1);
        drain("drain_ff01", 40);
        chk("carry_const_ff01", 32'(bus8.Carry), 32'd1);
        start8(1'b1, 8'h10, 8'h20, 1'b1);
        drain("drain_1020", 40);
        chk("sum_const_1020", 32'(bus8.SUM), 32'hF0);

        // Signed overflow on subtract; START in 3rd BUSY cycle must be ignored.
        d0 = done8;
        start8(1'b1, 8'h80, 8'h01, 1'b1);
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        chk("busy_at_ignored_start", 32'(bus8.BUSY), 32'd1);
        bus8.START = 1'b1;
        bus8.A     = 8'h00;
        bus8.MODE  = 1'b0;
        @(posedge CLK); #2;
        bus8.START = 1'b0;
        drain("drain_8001", 40);
        repeat (12) @(posedge CLK);
        #2;
        chk("single_done_8001", 32'(done8 - d0), 32'd1);
        chk("sum_hold_8001", 32'(bus8.SUM), 32'h7F);

        // Back-to-back with START held; operands change in the FINISH cycle.
        @(posedge CLK); #2;
        b0 = busy8;
        c0 = cyc;
        bus8.START = 1'b1;
        bus8.MODE  = 1'b0;
        bus8.A     = 8'h01;
        bus8.B     = 8'h01;
        e = model(8, 1'b0, 32'h01, 32'h01);
        e.cyc = c0 + 9;
        q8.push_back(e);
        repeat (9) @(posedge CLK);
        #2;
        chk("b2b_finish_busy", 32'(bus8.BUSY), 32'd0);
        chk("b2b_finish_done", 32'(bus8.DONE), 32'd1);
        bus8.A = 8'h02;
        bus8.B = 8'h02;
        e = model(8, 1'b0, 32'h02, 32'h02);
        e.cyc = c0 + 18;
        q8.push_back(e);
        @(posedge CLK); #2;
        bus8.START = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        chk("b2b_drained", 32'(q8.size()), 32'd0);
        chk("b2b_busy_cycles", 32'(busy8 - b0), 32'd16);
        chk("b2b_sum_const", 32'(bus8.SUM), 32'h04);

        // Asynchronous reset mid-operation aborts with no DONE.
        start8(1'b0, 8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        chk("abort_sum", 32'(bus8.SUM), 32'd0);
        chk("abort_carry", 32'(bus8.Carry), 32'd0);
        chk("abort_ovf", 32'(bus8.OVF), 32'd0);
        chk("abort_busy", 32'(bus8.BUSY), 32'd0);
        chk("abort_done", 32'(bus8.DONE), 32'd0);
        d0 = done8;
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        repeat (20) @(posedge CLK);
        #2;
        chk("abort_no_done", 32'(done8 - d0), 32'd0);
        start8(1'b0, 8'h01, 8'h02, 1'b1);
        drain("drain_0102", 40);
        chk("sum_const_0102", 32'(bus8.SUM), 32'h03);

        // A few more mixed operands through the scoreboard.
        start8(1'b1, 8'h7F, 8'h80, 1'b1);
        drain("drain_7f80", 40);
        start8(1'b0, 8'h7F, 8'h01, 1'b1);
        drain("drain_7f01", 40);
        start8(1'b1, 8'h00, 8'h00, 1'b1);
        drain("drain_0000", 40);

        // Minimum width: 0b11 + 0b01, DONE two cycles after capture.
        d0 = done2;
        start2(1'b0, 2'b11, 2'b01);
        drain("drain_w2", 20);
        chk("w2_done_count", 32'(done2 - d0), 32'd1);
        chk("w2_sum_const", 32'(bus2.SUM), 32'd0);
        chk("w2_carry_const", 32'(bus2.Carry), 32'd1);
        start2(1'b1, 2'b01, 2'b10);
        drain("drain_w2_sub", 20);

        repeat (5) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
